// File: rtl/wb_scoreboard_ctrl_pkg.sv
// Shared definitions for the writeback scoreboard.
//   NUM_REGS      : architectural GPR count tracked by the scoreboard
//   reg_code_t    : 4-bit register code, RAX..R15 constants below
//   SPECIAL_DEST  : register used as the implicit second destination
//   sb_state_t    : issue-control state {RUN, DRAIN, HALTED}
//   reg_ref_t     : {valid, code} register reference
//   decodeRef()   : one-hot register mask of a reference (zero when invalid)
package wb_scoreboard_ctrl_pkg;
   localparam int NUM_REGS = 16;
   localparam int REG_W    = 4;

   typedef logic [REG_W-1:0] reg_code_t;

   localparam reg_code_t RAX = 4'd0,  RCX = 4'd1,  RDX = 4'd2,  RBX = 4'd3;
   localparam reg_code_t RSP = 4'd4,  RBP = 4'd5,  RSI = 4'd6,  RDI = 4'd7;
   localparam reg_code_t R8  = 4'd8,  R9  = 4'd9,  R10 = 4'd10, R11 = 4'd11;
   localparam reg_code_t R12 = 4'd12, R13 = 4'd13, R14 = 4'd14, R15 = 4'd15;
   localparam reg_code_t SPECIAL_DEST = RDX;

   typedef enum logic [1:0] {RUN, DRAIN, HALTED} sb_state_t;

   typedef struct packed {
      logic      valid;
      reg_code_t code;
   } reg_ref_t;

   // OR-ing two decoded references counts a register once even when both
   // fields name it.
   function automatic logic [NUM_REGS-1:0] decodeRef(input reg_ref_t r);
      return r.valid ? (NUM_REGS'(1) << r.code) : '0;
   endfunction
endpackage

// File: rtl/wb_scoreboard_ctrl_sb_reg_counter.sv
// Per-register pending-write counter.
//   clk, reset : clock, synchronous active-high reset
//   rsv        : an issued instruction will write this register
//   rel        : a retiring instruction wrote this register
//   busy       : counter != 0
//   full       : counter at 2^CNT_W-1
//   underflow  : release seen with nothing pending (counter held at 0)
module sb_reg_counter #(
   parameter int CNT_W = 2
) (
   input  logic clk,
   input  logic reset,
   input  logic rsv,
   input  logic rel,
   output logic busy,
   output logic full,
   output logic underflow
);
   localparam logic [CNT_W-1:0] CNT_MAX = '1;

   logic [CNT_W-1:0] count;

   assign busy      = (count != '0);
   assign full      = (count == CNT_MAX);
   // A reserve in the same cycle covers the release, so no underflow then.
   assign underflow = rel && !rsv && !busy;

   always_ff @(posedge clk) begin
      if (reset)
         count <= '0;
      else if (rsv && !rel && !full)
         count <= count + 1'b1;
      else if (rel && !rsv && busy)
         count <= count - 1'b1;
   end
endmodule

// File: rtl/wb_scoreboard_ctrl.sv
// Registered issue scoreboard between decode/issue and writeback.
//   clk, reset                       : clock, synchronous active-high reset
//   issue_*                          : issue request (sources, dest, special dest)
//   issue_ready_out                  : grant, accepted on valid && ready
//   wb_*                             : retirement of one instruction + released regs
//   halt_req_in                      : request to stop issuing and drain
//   busy_map_out                     : bit r set while register r has pending writes
//   outstanding_out                  : instructions between issue and writeback
//   halted_out                       : drain finished, sticky until reset
//   error_out                        : sticky protocol error (release/retire underflow)
module wb_scoreboard_ctrl
   import wb_scoreboard_ctrl_pkg::*;
#(
   parameter int CNT_W    = 2,
   parameter int OUTS_MAX = 8,
   parameter int OUTS_W   = 4
) (
   input  logic                clk,
   input  logic                reset,
   input  logic                issue_valid_in,
   output logic                issue_ready_out,
   input  logic [3:0]          issue_src1_in,
   input  logic                issue_src1_valid_in,
   input  logic [3:0]          issue_src2_in,
   input  logic                issue_src2_valid_in,
   input  logic [3:0]          issue_dest_in,
   input  logic                issue_dest_valid_in,
   input  logic [3:0]          issue_dest_special_in,
   input  logic                issue_dest_special_valid_in,
   input  logic                wb_valid_in,
   input  logic [3:0]          wb_dest_in,
   input  logic                wb_dest_valid_in,
   input  logic [3:0]          wb_dest_special_in,
   input  logic                wb_dest_special_valid_in,
   input  logic                halt_req_in,
   output logic [NUM_REGS-1:0] busy_map_out,
   output logic [OUTS_W-1:0]   outstanding_out,
   output logic                halted_out,
   output logic                error_out
);
   logic [NUM_REGS-1:0] busyMap, fullMap, underMap, rsvMap, relMap;
   logic [OUTS_W-1:0]   outstanding;
   sb_state_t           state;
   logic                halted, error;
   logic                srcHazard, destFull, outsFull, accept, outsUnder;

   // Ready looks only at registered state: a writeback this cycle frees its
   // registers for issue starting next cycle.
   always_comb begin
      srcHazard = (issue_src1_valid_in && busyMap[issue_src1_in]) ||
                  (issue_src2_valid_in && busyMap[issue_src2_in]);
      destFull  = (issue_dest_valid_in && fullMap[issue_dest_in]) ||
                  (issue_dest_special_valid_in && fullMap[issue_dest_special_in]);
      outsFull  = (outstanding >= OUTS_W'(OUTS_MAX));
      issue_ready_out = (state == RUN) && !halt_req_in && !reset &&
                        !srcHazard && !outsFull && !destFull;
   end

   assign accept    = issue_valid_in && issue_ready_out;
   assign outsUnder = wb_valid_in && !accept && (outstanding == '0);

   assign rsvMap = accept ?
      (decodeRef(reg_ref_t'{issue_dest_valid_in, issue_dest_in}) |
       decodeRef(reg_ref_t'{issue_dest_special_valid_in, issue_dest_special_in})) : '0;
   assign relMap = wb_valid_in ?
      (decodeRef(reg_ref_t'{wb_dest_valid_in, wb_dest_in}) |
       decodeRef(reg_ref_t'{wb_dest_special_valid_in, wb_dest_special_in})) : '0;

   for (genvar r = 0; r < NUM_REGS; r++) begin : gCnt
      sb_reg_counter #(.CNT_W(CNT_W)) uCnt (
         .clk       (clk),
         .reset     (reset),
         .rsv       (rsvMap[r]),
         .rel       (relMap[r]),
         .busy      (busyMap[r]),
         .full      (fullMap[r]),
         .underflow (underMap[r])
      );
   end

   always_ff @(posedge clk) begin
      if (reset) begin
         state       <= RUN;
         outstanding <= '0;
         halted      <= 1'b0;
         error       <= 1'b0;
      end else begin
         error <= error | (|underMap) | outsUnder;

         if (accept && !wb_valid_in)
            outstanding <= outstanding + 1'b1;
         else if (wb_valid_in && !accept && (outstanding != '0))
            outstanding <= outstanding - 1'b1;

         case (state)
            RUN:    if (halt_req_in) state <= DRAIN;
            DRAIN:  if (outstanding == '0) begin
                       state  <= HALTED;
                       halted <= 1'b1;
                    end
            HALTED: ;
            default: state <= RUN;
         endcase
      end
   end

   assign busy_map_out    = busyMap;
   assign outstanding_out = outstanding;
   assign halted_out      = halted;
   assign error_out       = error;
endmodule
